// File: rtl/bno085_spi_arbiter_if.sv
// Controller-side and spi_master-side signals for the BNO085 SPI arbiter.
// The arbiter uses the slave modport; the requesters/spi_master side uses master.
interface bno085_spi_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       req_cs_n;
    logic [NUM_REQ-1:0]       req_start;
    logic [NUM_REQ-1:0]       req_tx_valid;
    logic [NUM_REQ-1:0][7:0]  req_tx_data;
    logic [NUM_REQ-1:0]       req_tx_ready;
    logic [NUM_REQ-1:0]       req_rx_valid;
    logic [7:0]               req_rx_data;
    logic [NUM_REQ-1:0]       req_busy;
    logic [NUM_REQ-1:0]       cs_n;
    logic                     spi_start;
    logic                     spi_tx_valid;
    logic [7:0]               spi_tx_data;
    logic                     spi_tx_ready;
    logic                     spi_rx_valid;
    logic [7:0]               spi_rx_data;
    logic                     spi_busy;
    logic                     timeout_err;

    modport slave (
        input  req, req_cs_n, req_start, req_tx_valid, req_tx_data,
               spi_tx_ready, spi_rx_valid, spi_rx_data, spi_busy,
        output gnt, req_tx_ready, req_rx_valid, req_rx_data, req_busy,
               cs_n, spi_start, spi_tx_valid, spi_tx_data, timeout_err
    );

    modport master (
        output req, req_cs_n, req_start, req_tx_valid, req_tx_data,
               spi_tx_ready, spi_rx_valid, spi_rx_data, spi_busy,
        input  gnt, req_tx_ready, req_rx_valid, req_rx_data, req_busy,
               cs_n, spi_start, spi_tx_valid, spi_tx_data, timeout_err
    );
endinterface

// File: rtl/bno085_spi_arbiter.sv
// Round-robin owner arbitration of one spi_master among NUM_REQ IMU controllers.
// Optional ARB_TIMEOUT_EN: forced release after HOLD_TIMEOUT cycles in GRANT, with lockout.
module bno085_spi_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int CS_GAP       = 30,
    parameter int HOLD_TIMEOUT = 300000
) (
    input logic                 clk,
    input logic                 rst,
    bno085_spi_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN, GAP} state_t;

    state_t             state;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] lockout;
    logic [NUM_REQ-1:0] eligible;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   last_owner;
    logic [IDX_W-1:0]   winner;
    logic [GAP_W-1:0]   gap_cnt;
    logic               timeout_q;
`ifdef ARB_TIMEOUT_EN
    logic [18:0]        hold_cnt;
`endif

    assign eligible = bus.req & ~lockout;

    // First eligible requester strictly after the previous owner, wrapping.
    always_comb begin : pick
        logic             found;
        logic [IDX_W-1:0] cand;
        found  = 1'b0;
        cand   = '0;
        winner = last_owner;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_owner) + k) % NUM_REQ);
            if (!found && eligible[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt_q      <= '0;
            owner      <= '0;
            last_owner <= IDX_W'(NUM_REQ - 1);
            gap_cnt    <= '0;
            lockout    <= '0;
            timeout_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt   <= '0;
`endif
        end else begin
            timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            lockout   <= lockout & bus.req;
`endif
            case (state)
                IDLE: if (|eligible) begin
                    state      <= GRANT;
                    gnt_q      <= NUM_REQ'(1) << winner;
                    owner      <= winner;
                    last_owner <= winner;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt   <= '0;
`endif
                end
                GRANT: if (!bus.req[owner]) begin
                    state <= DRAIN;
                    gnt_q <= '0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_cnt == 19'(HOLD_TIMEOUT - 1)) begin
                    state          <= DRAIN;
                    gnt_q          <= '0;
                    timeout_q      <= 1'b1;
                    lockout[owner] <= 1'b1;
                end else begin
                    hold_cnt <= hold_cnt + 19'd1;
                end
`endif
                DRAIN: if (!bus.spi_busy) begin
                    gap_cnt <= '0;
                    state   <= (CS_GAP > 0) ? GAP : IDLE;
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(CS_GAP - 1)) state <= IDLE;
                    else gap_cnt <= gap_cnt + GAP_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Owner-routed byte interface; CS of the owner stays under its control until spi_master goes idle.
    logic [NUM_REQ-1:0] tx_ready, rx_valid, busy, cs;
    logic               own_active;

    assign own_active = (state == GRANT) || (state == DRAIN);

    always_comb begin
        tx_ready = '0;
        rx_valid = '0;
        busy     = '1;
        cs       = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (own_active && owner == IDX_W'(i)) begin
                rx_valid[i] = bus.spi_rx_valid;
                busy[i]     = bus.spi_busy;
                tx_ready[i] = (state == GRANT) && bus.spi_tx_ready;
                if (state == GRANT || bus.spi_busy) cs[i] = bus.req_cs_n[i];
            end
        end
    end

    assign bus.spi_start    = (state == GRANT) && bus.req_start[owner];
    assign bus.spi_tx_valid = (state == GRANT) && bus.req_tx_valid[owner];
    assign bus.spi_tx_data  = (state == GRANT) ? bus.req_tx_data[owner] : 8'h00;
    assign bus.gnt          = gnt_q;
    assign bus.req_tx_ready = tx_ready;
    assign bus.req_rx_valid = rx_valid;
    assign bus.req_rx_data  = bus.spi_rx_data;
    assign bus.req_busy     = busy;
    assign bus.cs_n         = cs;
    assign bus.timeout_err  = timeout_q;
endmodule

// File: tb/tb_bno085_spi_arbiter.sv
// Directed vector table plus hand sequences for bno085_spi_arbiter (NUM_REQ=2, CS_GAP=30).
module tb_bno085_spi_arbiter;
    localparam int NUM_REQ      = 2;
    localparam int CS_GAP       = 30;
    localparam int HOLD_TIMEOUT = 100;
    localparam int LOW_CYCLES   = CS_GAP + 2;  // drain exit + gap + idle decision

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bno085_spi_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    bno085_spi_arbiter #(
        .NUM_REQ(NUM_REQ), .CS_GAP(CS_GAP), .HOLD_TIMEOUT(HOLD_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] req, rcs, rstart, rtxv;
        logic [7:0] d0, d1;
        logic       stxr, srxv;
        logic [7:0] srxd;
        logic       sbusy;
        logic [1:0] e_gnt, e_cs;
        logic       e_start, e_txv;
        logic [7:0] e_txd;
        logic [1:0] e_txr, e_rxv, e_busy;
    } vec_t;

    vec_t vt[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req          = '0;
        bus.req_cs_n     = '1;
        bus.req_start    = '0;
        bus.req_tx_valid = '0;
        bus.req_tx_data  = '0;
        bus.spi_tx_ready = 1'b0;
        bus.spi_rx_valid = 1'b0;
        bus.spi_rx_data  = 8'h00;
        bus.spi_busy     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Called at a negedge with gnt low; counts cycles until a grant, requiring all CS high meanwhile.
    task automatic wait_gnt(input string name, input logic [1:0] exp_gnt, input int exp_low);
        int low = 0;
        bit cs_high = 1'b1;
        while (bus.gnt == 2'b00 && low < 200) begin
            if (bus.cs_n !== 2'b11) cs_high = 1'b0;
            low++;
            @(negedge clk);
        end
        check({name, "_gnt"}, 32'(bus.gnt), 32'(exp_gnt));
        check({name, "_low_cycles"}, low, exp_low);
        check({name, "_cs_high"}, 32'(cs_high), 32'd1);
    endtask

    initial begin
        int   drained;
        int   held;
        bit   seen_err;
        bit   stray;

        //        req    rcs    rst    rtxv   d0     d1     stxr  srxv  srxd   busy | gnt   cs     st    txv   txd    txr    rxv    busy
        vt[0] = '{2'b00, 2'b11, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b11};
        vt[1] = '{2'b01, 2'b11, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b11};
        vt[2] = '{2'b01, 2'b10, 2'b01, 2'b01, 8'hA5, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b0, 2'b01, 2'b10, 1'b1, 1'b1, 8'hA5, 2'b01, 2'b00, 2'b10};
        vt[3] = '{2'b01, 2'b10, 2'b00, 2'b01, 8'h5A, 8'h3C, 1'b1, 1'b1, 8'h77, 1'b1, 2'b01, 2'b10, 1'b0, 1'b1, 8'h5A, 2'b01, 2'b01, 2'b11};
        vt[4] = '{2'b01, 2'b10, 2'b10, 2'b11, 8'hC3, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 2'b01, 2'b10, 1'b0, 1'b1, 8'hC3, 2'b01, 2'b00, 2'b11};
        vt[5] = '{2'b01, 2'b00, 2'b00, 2'b01, 8'h0F, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 2'b01, 2'b10, 1'b0, 1'b1, 8'h0F, 2'b00, 2'b00, 2'b11};
        vt[6] = '{2'b00, 2'b10, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 2'b01, 2'b10, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b11};
        vt[7] = '{2'b00, 2'b10, 2'b01, 2'b01, 8'h11, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b11};
        vt[8] = '{2'b00, 2'b10, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b10};
        vt[9] = '{2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b11};

        // Single owner transfer: reset state, grant, byte mux, non-owner isolation, drain, gap entry.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            bus.req            = vt[i].req;
            bus.req_cs_n       = vt[i].rcs;
            bus.req_start      = vt[i].rstart;
            bus.req_tx_valid   = vt[i].rtxv;
            bus.req_tx_data[0] = vt[i].d0;
            bus.req_tx_data[1] = vt[i].d1;
            bus.spi_tx_ready   = vt[i].stxr;
            bus.spi_rx_valid   = vt[i].srxv;
            bus.spi_rx_data    = vt[i].srxd;
            bus.spi_busy       = vt[i].sbusy;
            @(negedge clk);
            check($sformatf("v%0d_gnt", i), 32'(bus.gnt), 32'(vt[i].e_gnt));
            check($sformatf("v%0d_cs_n", i), 32'(bus.cs_n), 32'(vt[i].e_cs));
            check($sformatf("v%0d_spi_start", i), 32'(bus.spi_start), 32'(vt[i].e_start));
            check($sformatf("v%0d_spi_tx_valid", i), 32'(bus.spi_tx_valid), 32'(vt[i].e_txv));
            check($sformatf("v%0d_spi_tx_data", i), 32'(bus.spi_tx_data), 32'(vt[i].e_txd));
            check($sformatf("v%0d_req_tx_ready", i), 32'(bus.req_tx_ready), 32'(vt[i].e_txr));
            check($sformatf("v%0d_req_rx_valid", i), 32'(bus.req_rx_valid), 32'(vt[i].e_rxv));
            check($sformatf("v%0d_req_busy", i), 32'(bus.req_busy), 32'(vt[i].e_busy));
            check($sformatf("v%0d_req_rx_data", i), 32'(bus.req_rx_data), 32'(vt[i].srxd));
            check($sformatf("v%0d_timeout_err", i), 32'(bus.timeout_err), 32'd0);
        end

        // Both request together after reset; owner 0 drops while spi_master is busy for 8 cycles.
        do_reset();
        tick(); bus.req = 2'b11;
        @(negedge clk); check("a_pre_gnt", 32'(bus.gnt), 32'd0);
        tick(); bus.req_cs_n = 2'b10; bus.spi_busy = 1'b1;
        @(negedge clk);
        check("a_first_gnt", 32'(bus.gnt), 32'b01);
        check("a_first_cs", 32'(bus.cs_n), 32'b10);
        tick(); bus.req = 2'b10;
        @(negedge clk); check("a_drop_still_gnt", 32'(bus.gnt), 32'b01);
        drained = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk);
            if (bus.cs_n === 2'b10 && bus.gnt === 2'b00) drained++;
        end
        check("a_drain_cs_held", drained, 8);
        tick(); bus.spi_busy = 1'b0; bus.req_cs_n = 2'b00;
        @(negedge clk);
        wait_gnt("a_gap", 2'b10, LOW_CYCLES);
        check("a_owner1_cs", 32'(bus.cs_n), 32'b01);

        // Owner 1 active: requester 0's start/tx are ignored.
        tick(); bus.spi_tx_ready = 1'b1; bus.req_start = 2'b01; bus.req_tx_valid = 2'b01;
        @(negedge clk);
        check("iso_spi_start", 32'(bus.spi_start), 32'd0);
        check("iso_spi_tx_valid", 32'(bus.spi_tx_valid), 32'd0);
        check("iso_tx_ready", 32'(bus.req_tx_ready), 32'b10);
        check("iso_busy", 32'(bus.req_busy), 32'b01);

        // Synchronous reset mid-byte with owner 1.
        tick(); bus.req_start = 2'b10; bus.spi_busy = 1'b1;
        @(negedge clk); check("b_pre_start", 32'(bus.spi_start), 32'd1);
        tick(); rst = 1'b1;
        tick();
        @(negedge clk);
        check("b_rst_gnt", 32'(bus.gnt), 32'd0);
        check("b_rst_cs", 32'(bus.cs_n), 32'b11);
        check("b_rst_start", 32'(bus.spi_start), 32'd0);
        rst = 1'b0;

        // Round-robin fairness and single-requester back-to-back grants.
        do_reset();
        tick(); bus.req = 2'b10;
        tick();
        @(negedge clk); check("c_only1_gnt", 32'(bus.gnt), 32'b10);
        tick(); bus.req = 2'b00;
        tick(); bus.req = 2'b11;
        @(negedge clk);
        wait_gnt("c_rr_fair", 2'b01, LOW_CYCLES);
        tick(); bus.req = 2'b10;
        tick();
        @(negedge clk);
        wait_gnt("c_rr_next", 2'b10, LOW_CYCLES);
        tick(); bus.req = 2'b00;
        tick(); bus.req = 2'b10;
        @(negedge clk);
        wait_gnt("c_single", 2'b10, LOW_CYCLES);

        // Hold behaviour: forced release with lockout when enabled, unlimited hold otherwise.
        do_reset();
        tick(); bus.req = 2'b01;
        tick();
        @(negedge clk);
`ifdef ARB_TIMEOUT_EN
        held = 0;
        while (bus.gnt == 2'b01 && held < 1000) begin
            held++;
            @(negedge clk);
        end
        check("t_hold_cycles", held, HOLD_TIMEOUT);
        check("t_err_pulse", 32'(bus.timeout_err), 32'd1);
        check("t_gnt_off", 32'(bus.gnt), 32'd0);
        @(negedge clk);
        check("t_err_one_cycle", 32'(bus.timeout_err), 32'd0);
        stray = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.gnt !== 2'b00) stray = 1'b1;
        end
        check("t_lockout", 32'(stray), 32'd0);
        tick(); bus.req = 2'b00;
        tick(); bus.req = 2'b01;
        tick();
        @(negedge clk); check("t_regrant", 32'(bus.gnt), 32'b01);
`else
        held = 0;
        seen_err = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (bus.gnt === 2'b01) held++;
            if (bus.timeout_err !== 1'b0) seen_err = 1'b1;
            @(negedge clk);
        end
        check("t_unlimited_hold", held, 150);
        check("t_no_err", 32'(seen_err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
